// File: rtl/instruction_pkg.sv
// Shared RV32 instruction-side definitions: fetch reset address, word size,
// major opcode encodings and the fetch-stage state type.
package instruction_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] IMEM_WORD_BYTES  = 32'd4;

    typedef enum logic [6:0] {
        OP_LOAD     = 7'b0000011,
        OP_MISC_MEM = 7'b0001111,
        OP_IMM      = 7'b0010011,
        OP_AUIPC    = 7'b0010111,
        OP_STORE    = 7'b0100011,
        OP_REG      = 7'b0110011,
        OP_LUI      = 7'b0110111,
        OP_BRANCH   = 7'b1100011,
        OP_JALR     = 7'b1100111,
        OP_JAL      = 7'b1101111,
        OP_SYSTEM   = 7'b1110011
    } opcode_e;

    typedef enum logic {
        FETCH_RESET,
        FETCH_RUN
    } fetch_state_e;

endpackage

// File: rtl/fetch_pc_fifo.sv
// Two-entry FIFO holding the PC of each in-flight fetch request, so every
// response can be paired with its address. Push and pop may share a cycle.
module fetch_pc_fifo
    import instruction_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  logic        pop,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        full,
    output logic        empty
);

    logic [31:0] mem [2];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  count;
    logic        do_push;
    logic        do_pop;

    assign empty   = (count == 2'd0);
    assign full    = (count == 2'd2);
    assign dout    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a push when an entry leaves in the same cycle.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) wr_ptr <= ~wr_ptr;
            if (do_pop)  rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/fetch.sv
// In-order RV32 instruction fetch: issues word requests, tracks up to two in
// flight, applies redirects from execution and discards wrong-path responses.
module fetch
    import instruction_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = RESET_PC_DEFAULT,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pc_v_x,
    input  logic [31:0] pc_x,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_o,
    output logic        inst_v_o,
    output logic [31:0] inst_o
);

    localparam logic [1:0] MAX_OUT = 2'(MAX_OUTSTANDING);

    fetch_state_e state;
    logic [31:0]  pc_q;
    logic [31:0]  redirect_pc;
    logic [31:0]  fifo_pc;
    logic [1:0]   outstanding;
    logic [1:0]   outstanding_after_rsp;
    logic [1:0]   drop_cnt;
    logic         rsp;
    logic         grant;
    logic         fifo_full;
    logic         fifo_empty;

    assign redirect_pc = pc_x & ~32'h3;

    // Responses during reset, or with nothing in flight, are not ours.
    assign rsp                   = imem_rvalid && !reset && !fifo_empty;
    assign outstanding_after_rsp = outstanding - {1'b0, rsp};

    assign imem_req  = !reset && (state == FETCH_RUN)
                       && (outstanding_after_rsp < MAX_OUT)
                       && (!fifo_full || rsp);
    assign imem_addr = pc_v_x ? redirect_pc : pc_q;
    assign grant     = imem_req && imem_gnt;

    assign inst_v_o = rsp && (drop_cnt == 2'd0) && !pc_v_x;
    assign inst_o   = imem_rdata;
    assign pc_o     = fifo_pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= FETCH_RESET;
            pc_q        <= RESET_PC;
            outstanding <= 2'd0;
            drop_cnt    <= 2'd0;
        end else begin
            if (state == FETCH_RESET) state <= FETCH_RUN;

            if (grant)       pc_q <= imem_addr + IMEM_WORD_BYTES;
            else if (pc_v_x) pc_q <= redirect_pc;

            outstanding <= outstanding_after_rsp + {1'b0, grant};

            // A request granted alongside the redirect already fetches the
            // target, so only the older survivors are marked for discard.
            if (pc_v_x)                         drop_cnt <= outstanding_after_rsp;
            else if (rsp && (drop_cnt != 2'd0)) drop_cnt <= drop_cnt - 2'd1;
        end
    end

    fetch_pc_fifo u_pc_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (grant),
        .pop   (rsp),
        .din   (imem_addr),
        .dout  (fifo_pc),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_fetch.sv
// Bench for the fetch stage: a vector table of per-cycle memory/redirect
// stimulus with a response scoreboard, followed by a randomised run.
module tb_fetch;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pc_v_x = 1'b0;
    logic [31:0] pc_x = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] pc_o;
    logic        inst_v_o;
    logic [31:0] inst_o;

    fetch dut (
        .clk         (clk),
        .reset       (reset),
        .pc_v_x      (pc_v_x),
        .pc_x        (pc_x),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .pc_o        (pc_o),
        .inst_v_o    (inst_v_o),
        .inst_o      (inst_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        redir;
        logic [31:0] tgt;
        logic        gnt;
        int          lat;
        logic        chk;
        logic [31:0] addr;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          killed;
    } pend_t;

    vec_t  vecs[$];
    pend_t pending[$];
    int    total = 0;
    int    bad = 0;
    int    cyc = 0;
    int    since_rst = 0;
    logic  prev_stall = 1'b0;
    logic [31:0] prev_addr = 32'h0;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return (a ^ 32'h5A5A_1234) + 32'h0000_0013;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic v(input logic rst, input logic redir, input logic [31:0] tgt,
                     input logic gnt, input int lat, input logic chk, input logic [31:0] addr);
        vec_t r;
        r.rst = rst; r.redir = redir; r.tgt = tgt; r.gnt = gnt;
        r.lat = lat; r.chk = chk; r.addr = addr;
        vecs.push_back(r);
    endtask

    task automatic step(input vec_t r);
        pend_t h;
        pend_t t;
        logic  rsp;
        logic  exp_v;
        int    n_after;
        if (r.rst) begin
            reset = 1'b1; pc_v_x = 1'b0; pc_x = 32'h0; imem_gnt = r.gnt;
            imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
            #1;
            check("req_in_reset", {31'b0, imem_req}, 32'd0);
            check("vld_in_reset", {31'b0, inst_v_o}, 32'd0);
            pending.delete();
            since_rst = 0;
            prev_stall = 1'b0;
        end else begin
            reset = 1'b0; pc_v_x = r.redir; pc_x = r.tgt; imem_gnt = r.gnt;
            rsp = (pending.size() > 0) && (pending[0].due <= cyc);
            imem_rvalid = rsp;
            imem_rdata = rsp ? mem_data(pending[0].addr) : $urandom;
            #1;
            n_after = pending.size() - (rsp ? 1 : 0);
            check("req", {31'b0, imem_req}, {31'b0, (since_rst >= 1) && (n_after < 2)});
            if (r.chk) check("addr", imem_addr, r.addr);
            if (r.redir && imem_req) check("redir_addr", imem_addr, r.tgt & ~32'h3);
            if (prev_stall && !r.redir) check("addr_hold", imem_addr, prev_addr);
            if (rsp) begin
                h = pending.pop_front();
                exp_v = !h.killed && !r.redir;
                check("inst_v", {31'b0, inst_v_o}, {31'b0, exp_v});
                if (exp_v) begin
                    check("pc_o", pc_o, h.addr);
                    check("inst_o", inst_o, mem_data(h.addr));
                end
            end else begin
                check("inst_v_idle", {31'b0, inst_v_o}, 32'd0);
            end
            if (r.redir) begin
                for (int i = 0; i < pending.size(); i++) begin
                    t = pending[i];
                    t.killed = 1'b1;
                    pending[i] = t;
                end
            end
            if (imem_req && r.gnt) begin
                t.addr = imem_addr; t.due = cyc + r.lat; t.killed = 1'b0;
                pending.push_back(t);
            end
            prev_stall = imem_req && !r.gnt;
            prev_addr = imem_addr;
            since_rst++;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        vec_t r;
        // reset, then sequential fetch with 1-cycle memory
        v(1,0,0,0,1,0,0); v(1,0,0,0,1,0,0);
        v(0,0,0,1,1,0,0);
        v(0,0,0,1,1,1,32'h0);  v(0,0,0,1,1,1,32'h4);
        v(0,0,0,1,1,1,32'h8);  v(0,0,0,1,1,1,32'hC);
        // grant withheld three cycles at 0x10
        v(0,0,0,0,1,1,32'h10); v(0,0,0,0,1,1,32'h10); v(0,0,0,0,1,1,32'h10);
        v(0,0,0,1,1,1,32'h10); v(0,0,0,1,1,1,32'h14);
        v(0,0,0,1,1,1,32'h18); v(0,0,0,1,1,1,32'h1C);
        // two slow requests in flight, then redirect to 0x200
        v(0,0,0,1,3,1,32'h20); v(0,0,0,1,3,1,32'h24);
        v(0,1,32'h200,1,1,0,0);
        v(0,0,0,1,1,1,32'h200);
        v(0,0,0,0,1,1,32'h204); v(0,0,0,0,1,1,32'h204); v(0,0,0,0,1,1,32'h204);
        // redirect colliding with the 0x30 response
        v(0,1,32'h30,1,1,1,32'h30);
        v(0,1,32'h100,1,1,1,32'h100);
        v(0,0,0,0,1,1,32'h104);
        // wraparound and unaligned target
        v(0,1,32'hFFFF_FFFC,1,1,1,32'hFFFF_FFFC);
        v(0,0,0,1,1,1,32'h0);
        v(0,0,0,0,1,1,32'h4);
        v(0,1,32'h103,1,1,1,32'h100);
        v(0,0,0,1,1,1,32'h104);
        v(0,0,0,0,1,1,32'h108);
        // reset with two requests in flight and one pending discard
        v(0,0,0,1,3,1,32'h108); v(0,0,0,1,3,1,32'h10C);
        v(0,1,32'h400,1,3,0,0);
        v(0,0,0,1,3,1,32'h400);
        v(1,0,0,1,1,0,0); v(1,0,0,1,1,0,0);
        v(0,0,0,1,1,0,0);
        v(0,0,0,1,1,1,32'h0);
        v(0,0,0,0,1,1,32'h4); v(0,0,0,0,1,1,32'h4);

        @(negedge clk);
        foreach (vecs[i]) step(vecs[i]);

        for (int i = 0; i < 400; i++) begin
            r.rst   = 1'b0;
            r.redir = ($urandom_range(0, 9) == 0);
            r.tgt   = $urandom;
            r.gnt   = ($urandom_range(0, 3) != 0);
            r.lat   = $urandom_range(1, 3);
            r.chk   = 1'b0;
            r.addr  = 32'h0;
            step(r);
        end
        // drain whatever is still in flight
        for (int i = 0; i < 8; i++) begin
            r.rst = 1'b0; r.redir = 1'b0; r.tgt = 32'h0; r.gnt = 1'b0;
            r.lat = 1; r.chk = 1'b0; r.addr = 32'h0;
            step(r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch.md
# fetch

In-order instruction fetch stage for the RV32 core. It issues word requests to instruction memory, tracks up to two outstanding requests, and delivers each returned instruction with its PC to the execution stage. It applies branch redirects (`pc_v_x`/`pc_x`) from execution and discards wrong-path responses. Execution never stalls, so this block produces at most one instruction per cycle with no backpressure on its output.

## Interface
Parameters:
- `RESET_PC`, default `32'h0000_0000`: first fetch address after reset.
- `MAX_OUTSTANDING`, default `2`: maximum number of accepted requests still awaiting a response. Legal values are 1 or 2.

Ports:
- `clk`  in  1  clock. One clock domain only. Reset is synchronous and active-high.
- `reset`  in  1  synchronous active-high reset.
- `pc_v_x`  in  1  redirect valid, from execution.
- `pc_x`  in  32  redirect target. Bits [1:0] are ignored and treated as 0.
- `imem_req`  out  1  request valid.
- `imem_addr`  out  32  word-aligned request address.
- `imem_gnt`  in  1  request accepted this cycle, when asserted with `imem_req`.
- `imem_rvalid`  in  1  response valid. Responses arrive in request order, at least 1 cycle after grant.
- `imem_rdata`  in  32  response instruction word.
- `pc_o`  out  32  PC of the delivered instruction.
- `inst_v_o`  out  1  delivered instruction valid. Consumed unconditionally on every cycle it is high.
- `inst_o`  out  32  delivered instruction.

## Operation
- Registers:
  - `pc_q`: next fetch address.
  - `outstanding`: count of granted requests awaiting response, range 0..2.
  - `drop_cnt`: number of upcoming responses to discard, range 0..2.
  - PC FIFO: one entry per outstanding request.
- FSM states:
  - `RESET`: occupies the first cycle after `reset` deasserts; no request is issued. Moves to `RUN`.
  - `RUN`: normal operation.
- Request issue, in `RUN`:
  - `imem_req = (outstanding_after_rsp < MAX_OUTSTANDING)`, where `outstanding_after_rsp` is `outstanding` minus 1 if `imem_rvalid` is high this cycle.
  - `imem_addr = pc_v_x ? {pc_x[31:2],2'b00} : pc_q`.
- On grant:
  - Push `imem_addr` into the PC FIFO.
  - `pc_q <= imem_addr + 4`, wrapping modulo 2^32.
  - `outstanding` increments.
- Redirect with no grant: `pc_q <= {pc_x[31:2],2'b00}`.
- On response:
  - Pop the PC FIFO; `outstanding` decrements.
  - If `drop_cnt != 0`: discard the response and decrement `drop_cnt`.
  - Otherwise: `inst_v_o = !pc_v_x`, `inst_o = imem_rdata`, `pc_o` = popped PC. Outputs are combinational from the response.
- Redirect kill:
  - A response arriving in the same cycle as `pc_v_x` is wrong-path and is suppressed.
  - `drop_cnt <= outstanding_after_rsp`. This excludes any request granted in the redirect cycle, because that request fetches `pc_x`.
- Simultaneous grant and response: `outstanding` is unchanged, and the FIFO pushes and pops in the same cycle.
- `reset`, including mid-operation:
  - `pc_q <= RESET_PC`; `outstanding`, `drop_cnt` and the FIFO are cleared; the FSM goes to `RESET`.
  - Responses that arrive while `reset` is high are ignored.
  - Memory must not return responses to pre-reset requests after reset deasserts.

## Timing
- Reset values:
  - `imem_req = 0` during `reset` and in the `RESET` cycle.
  - `inst_v_o = 0`.
  - `pc_o` and `inst_o` are don't-care while `inst_v_o = 0`.
- First request carries `RESET_PC` on the second cycle after `reset` deasserts.
- Latency: the instruction is presented in the same cycle as `imem_rvalid`, with zero added delay.
- Throughput: with 1-cycle memory latency and `MAX_OUTSTANDING=2`, one instruction per cycle in steady state.
- Redirect penalty with 1-cycle memory: `pc_v_x` in cycle N, request for `pc_x` in cycle N, instruction at `pc_x` delivered in cycle N+1.
- Requests are held stable while `imem_req && !imem_gnt`, except that a redirect replaces `imem_addr` in its own cycle.

## Structure
- `RESET_PC` default and `IMEM_WORD_BYTES = 4` belong in `instruction_pkg`, alongside the opcode enums.
- One sub-module: `fetch_pc_fifo`, a 2-entry synchronous FIFO of 32-bit PCs.
  - Supports push and pop in the same cycle.
  - Provides `full`/`empty` flags.
  - Clears on `reset`.

## Test plan
- Reset release, `RESET_PC=0`, memory with 1-cycle latency and `gnt` always high -> addresses 0, 4, 8, 12 on consecutive cycles; `inst_v_o` in each following cycle with `pc_o` = 0, 4, 8….
- `imem_gnt` held low 3 cycles at addr 0x10 -> `imem_addr` stays 0x10, no duplicate FIFO entries; after grant, responses deliver 0x10 then 0x14 in order.
- `pc_v_x=1`, `pc_x=0x200` with two requests (0x20, 0x24) outstanding -> both responses discarded, `inst_v_o` stays low; first delivered `pc_o=0x200`.
- Response for 0x30 arriving in the same cycle as `pc_v_x`, `pc_x=0x100` -> `inst_v_o=0` that cycle; the request that cycle carries addr 0x100.
- Wrap: `pc_x=0xFFFF_FFFC` -> next request addr 0x0000_0000; `pc_x=0x103` -> request addr 0x100.
- `reset` asserted with 2 requests outstanding and `drop_cnt=1` -> counters and FIFO cleared; after reset deasserts, first request is `RESET_PC` and first delivered `pc_o=RESET_PC`.
